arm_prog_loader: RTL and testbench
==================================

ARM_PROG_LOADER -- requirements
Module: arm_prog_loader

Interface
REQ-001 Parameter DEPTH, default 1024: max words loadable into instruction memory.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of first written word.
REQ-003 Parameter HOLD_CYC, default 4: cycles cpu_rst stays high after last write.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a program load.
REQ-007 byte_valid  in  1  byte_data holds a valid stream byte.
REQ-008 byte_data  in  8  program stream byte.
REQ-009 byte_ready  out  1  loader can accept a byte this cycle.
REQ-010 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  out  32  byte address of the word being written.
REQ-012 imem_wdata  out  32  assembled instruction word.
REQ-013 cpu_rst  out  1  active-high reset driven into ARM_cpu.
REQ-014 load_done  out  1  program loaded, CPU released.
REQ-015 load_err  out  1  header word count exceeded DEPTH.

Function
REQ-016 Byte transfer SHALL occur only on a rising edge where byte_valid and byte_ready are both 1; byte_data SHALL be ignored otherwise.
REQ-017 FSM states SHALL be IDLE, HDR, DATA, WRITE, HOLD, RUN, ERR.
REQ-018 IDLE: byte_ready=0, cpu_rst=1; start=1 -> HDR.
REQ-019 HDR: byte_ready=1; two bytes accepted form 16-bit count N, low byte first; after second byte: N=0 -> HOLD, N>DEPTH -> ERR, else -> DATA.
REQ-020 DATA: byte_ready=1; four bytes accepted form one word little-endian (first byte -> bits 7:0); after fourth byte -> WRITE.
REQ-021 WRITE: byte_ready=0, imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*idx, imem_wdata=assembled word; idx increments; idx reaching N -> HOLD, else -> DATA.
REQ-022 Latency: imem_we SHALL assert the cycle after the fourth byte of a word is accepted; with byte_valid held high, one word per 5 cycles.
REQ-023 HOLD: cpu_rst=1 for exactly HOLD_CYC cycles, then -> RUN.
REQ-024 RUN: cpu_rst=0, load_done=1; start=1 -> HDR with cpu_rst=1 and load_done=0 from the next cycle, idx cleared.
REQ-025 ERR: load_err=1, cpu_rst=1, byte_ready=0; start=1 -> HDR with load_err cleared.
REQ-026 start SHALL be ignored in HDR, DATA, WRITE, HOLD.
REQ-027 idx SHALL be log2(DEPTH)+1 bits; N=DEPTH SHALL be accepted, N=DEPTH+1 SHALL go to ERR.
REQ-028 imem_addr and imem_wdata SHALL hold their last values outside WRITE; imem_we SHALL be 0 outside WRITE.
REQ-029 cpu_rst SHALL be 1 in every state except RUN.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE, idx=0, partial word/count cleared, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0.
REQ-031 Reset mid-load SHALL discard partial bytes; no imem_we SHALL occur during or on the cycle after reset.

Structure
REQ-032 FSM state encodings and default DEPTH/HOLD_CYC/BASE_ADDR SHALL live in shared package arm_loader_pkg.
REQ-033 Byte-to-word assembly (byte counter, shift register, word_ready pulse) SHALL be sub-module arm_word_packer.

Verification
REQ-034 Reset then start, stream 02 00 | 78 56 34 12 | EF BE AD DE with valid held -> writes 32'h12345678 @0x0, 32'hDEADBEEF @0x4; cpu_rst falls 4 cycles after second write; load_done=1.
REQ-035 Header 00 00 -> no imem_we, HOLD then RUN, load_done=1 after 4 cycles.
REQ-036 Header 01 04 (N=1025, DEPTH=1024) -> ERR, load_err=1, cpu_rst=1, byte_ready=0; start -> HDR, load_err=0.
REQ-037 Byte_valid toggling every other cycle during N=1 load of AA BB CC DD -> single write 32'hDDCCBBAA @0x0, no byte lost or duplicated.
REQ-038 rst=0 after two data bytes, then rst=1, start, full N=1 load of 01 00 00 00 -> single write 32'h00000001 @0x0.
REQ-039 start pulse while in RUN -> cpu_rst=1 next cycle, load_done=0, new load writes from BASE_ADDR.

Source files
------------

// File: rtl/arm_loader_pkg.sv
// Shared definitions for the ARM program loader: FSM encoding, default
// geometry and a small address helper used by the top level.
package arm_loader_pkg;

  localparam int          LOADER_DEPTH     = 1024;
  localparam int          LOADER_HOLD_CYC  = 4;
  localparam logic [31:0] LOADER_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

  // Byte address of word number idx in a word-addressed image starting at base.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/arm_word_packer.sv
// Little-endian byte-to-word assembler. Completes after two bytes in header
// mode or four bytes otherwise; o_word_ready pulses in the accepting cycle.
module arm_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_hdr_mode,
  input  logic        i_take,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        w_last;
  logic [31:0] w_word;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_word = r_word;
    w_last = i_hdr_mode ? (r_cnt == 2'd1) : (r_cnt == 2'd3);
    unique case (r_cnt)
      2'd0:    w_word[7:0]   = i_byte;
      2'd1:    w_word[15:8]  = i_byte;
      2'd2:    w_word[23:16] = i_byte;
      default: w_word[31:24] = i_byte;
    endcase
  end

  // The completed word is presented combinationally so the writer can
  // register it on the same edge that accepts the final byte.
  assign o_word_ready = i_take & w_last;
  assign o_word       = w_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_take) begin
      if (w_last) begin
        r_cnt  <= 2'd0;
        r_word <= 32'd0;
      end else begin
        r_cnt  <= r_cnt + 2'd1;
        r_word <= w_word;
      end
    end
  end

endmodule

// File: rtl/arm_prog_loader.sv
// Streams a length-prefixed program image into instruction memory while
// holding the CPU in reset, then releases it after a fixed hold period.
module arm_prog_loader
  import arm_loader_pkg::*;
#(
  parameter int          DEPTH     = LOADER_DEPTH,
  parameter logic [31:0] BASE_ADDR = LOADER_BASE_ADDR,
  parameter int          HOLD_CYC  = LOADER_HOLD_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int IW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

  loader_state_e r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_count;
  logic [HW-1:0] r_hold_cnt;
  logic          r_byte_ready;
  logic          r_imem_we;
  logic [31:0]   r_imem_addr;
  logic [31:0]   r_imem_wdata;
  logic          r_cpu_rst;
  logic          r_load_done;
  logic          r_load_err;

  logic          w_take;
  logic          w_clear;
  logic          w_hdr_mode;
  logic          w_word_ready;
  logic [31:0]   w_word;
  logic [15:0]   w_hdr_count;

  assign w_take      = byte_valid & r_byte_ready;
  assign w_hdr_mode  = (r_state == ST_HDR);
  assign w_clear     = start & ((r_state == ST_IDLE) | (r_state == ST_RUN) |
                                (r_state == ST_ERR));
  assign w_hdr_count = w_word[15:0];

  arm_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_hdr_mode   (w_hdr_mode),
    .i_take       (w_take),
    .i_byte       (byte_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_count      <= '0;
      r_hold_cnt   <= '0;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_imem_wdata <= 32'd0;
      r_cpu_rst    <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_HDR;
            r_byte_ready <= 1'b1;
            r_idx        <= '0;
          end
        end
        ST_HDR: begin
          if (w_word_ready) begin
            if (w_hdr_count == 16'd0) begin
              r_state      <= ST_HOLD;
              r_byte_ready <= 1'b0;
              r_hold_cnt   <= HW'(HOLD_CYC - 1);
            end else if (32'(w_hdr_count) > 32'(DEPTH)) begin
              r_state      <= ST_ERR;
              r_byte_ready <= 1'b0;
              r_load_err   <= 1'b1;
            end else begin
              r_state <= ST_DATA;
              r_count <= IW'(w_hdr_count);
            end
          end
        end
        ST_DATA: begin
          if (w_word_ready) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b1;
            r_imem_addr  <= word_byte_addr(BASE_ADDR, 32'(r_idx));
            r_imem_wdata <= w_word;
            r_idx        <= r_idx + IW'(1);
          end
        end
        ST_WRITE: begin
          // r_idx already counts the word just written.
          if (r_idx == r_count) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HW'(HOLD_CYC - 1);
          end else begin
            r_state      <= ST_DATA;
            r_byte_ready <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state     <= ST_RUN;
            r_cpu_rst   <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
          end
        end
        ST_RUN: begin
          if (start) begin
            r_state      <= ST_HDR;
            r_cpu_rst    <= 1'b1;
            r_load_done  <= 1'b0;
            r_byte_ready <= 1'b1;
            r_idx        <= '0;
          end
        end
        ST_ERR: begin
          if (start) begin
            r_state      <= ST_HDR;
            r_load_err   <= 1'b0;
            r_byte_ready <= 1'b1;
            r_idx        <= '0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_rst    <= 1'b1;
          r_load_done  <= 1'b0;
          r_load_err   <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_arm_prog_loader.sv
// Self-checking bench for arm_prog_loader: directed scenarios plus randomized
// loads compared against a byte-stream model of the expected memory image.
module tb_arm_prog_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          HOLD  = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  arm_prog_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write with the cycle it was visible in.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: valid held, 1: valid every other cycle, 2: random valid + stray start
  task automatic send_bytes(input logic [7:0] bq[$], input int mode);
    int i = 0;
    int g = 0;
    bit ph = 1'b0;
    bit v;
    acc_q.delete();
    while (i < bq.size() && g < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = ~ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = v ? bq[i] : 8'($urandom);
      start      = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (v && byte_ready === 1'b1) begin
        acc_q.push_back(cyc + 1);
        i++;
      end
      tick();
      g++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (g >= 20000) check("send_timeout", 32'(i), 32'(bq.size()));
  endtask

  // Full load: header N, 4*N data bytes (random when the data queue is empty),
  // then compare the observed writes and release timing with the image model.
  task automatic run_load(input string tag, input int n, input logic [7:0] data[$],
                          input int mode);
    logic [7:0]  d[$];
    logic [7:0]  s[$];
    logic [31:0] w;
    int          g;
    int          exp_run;
    d = data;
    if (d.size() == 0)
      for (int k = 0; k < 4 * n; k++) d.push_back(8'($urandom));
    s.delete();
    s.push_back(8'(n & 255));
    s.push_back(8'(n >> 8));
    foreach (d[k]) s.push_back(d[k]);
    clear_writes();
    pulse_start();
    send_bytes(s, mode);
    g = 0;
    while (load_done !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    exp_run = acc_q[acc_q.size() - 1] + ((n == 0) ? HOLD : HOLD + 1);
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_run_cycle"}, 32'(cyc), 32'(exp_run));
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
    for (int j = 0; j < n && j < wr_addr_q.size(); j++) begin
      w = 32'(d[4*j]) | (32'(d[4*j+1]) << 8) | (32'(d[4*j+2]) << 16) | (32'(d[4*j+3]) << 24);
      check({tag, "_addr"}, wr_addr_q[j], BASE + 32'(4 * j));
      check({tag, "_wdata"}, wr_data_q[j], w);
      check({tag, "_latency"}, 32'(wr_cyc_q[j]), 32'(acc_q[4*j+5]));
      if (j == n - 1) begin
        check({tag, "_addr_hold"}, imem_addr, BASE + 32'(4 * j));
        check({tag, "_wdata_hold"}, imem_wdata, w);
      end
    end
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] empty_q[$];
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();

    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_byte_ready", 32'(byte_ready), 32'd0);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);

    d = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("basic", 2, d, 0);
    check("basic_word0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h12345678);

    // Restart from RUN.
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(load_done), 32'd0);
    check("restart_ready", 32'(byte_ready), 32'd1);
    run_load("restart", 2, empty_q, 0);

    run_load("hdr0", 0, empty_q, 0);

    // Oversized header.
    clear_writes();
    pulse_start();
    d = {8'h01, 8'h04};
    send_bytes(d, 0);
    check("err_flag", 32'(load_err), 32'd1);
    check("err_cpu_rst", 32'(cpu_rst), 32'd1);
    check("err_ready", 32'(byte_ready), 32'd0);
    check("err_done", 32'(load_done), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) tick();
    byte_valid = 1'b0;
    check("err_sticky", 32'(load_err), 32'd1);
    check("err_nwrites", 32'(wr_addr_q.size()), 32'd0);
    pulse_start();
    check("err_clear", 32'(load_err), 32'd0);
    check("err_hdr_ready", 32'(byte_ready), 32'd1);

    d = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("toggle", 1, d, 1);
    check("toggle_word", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'hDDCCBBAA);

    // Reset in the middle of a word.
    clear_writes();
    pulse_start();
    d = {8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(d, 0);
    rst = 1'b0;
    tick();
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_we_after", 32'(imem_we), 32'd0);
    check("midrst_nwrites", 32'(wr_addr_q.size()), 32'd0);
    d = {8'h01, 8'h00, 8'h00, 8'h00};
    run_load("after_rst", 1, d, 0);
    check("after_rst_word", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h00000001);

    for (int r = 0; r < 6; r++) run_load("rand", int'($urandom_range(1, 6)), empty_q, 2);

    run_load("full_depth", DEPTH, empty_q, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
